// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Initiator side of the ALU en/operation/valid handshake. Takes one RV32I
// instruction at a time from fetch, decodes it into an ALU operation and
// operands, strobes the ALU, waits (bounded) for its answer and writes the
// result back to the register file.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  fetch handshake; ready only while idle
//   instr, pc                instruction word and its address
//   rs1_addr/rs2_addr        regfile read addresses from the latched instr
//   rs1_data/rs2_data        combinational regfile read data
//   alu_en                   one-cycle issue strobe
//   alu_op, alu_a, alu_b     registered ALU operation and operands
//   alu_valid, alu_result    ALU answer
//   rd_we, rd_addr, rd_wdata regfile write port (rd_we one cycle)
//   jump_valid, jump_target  JAL target pulse
//   illegal                  pulse for unsupported instructions
//   timeout_err              pulse when the ALU does not answer in time
module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             alu_en,
  output logic [4:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rd_we,
  output logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] rd_wdata,
  output logic             jump_valid,
  output logic [WIDTH-1:0] jump_target,
  output logic             illegal,
  output logic             timeout_err
);

  localparam int            CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t state, state_next;

  logic [31:0]      instr_q;
  logic [WIDTH-1:0] pc_q;
  logic [CW-1:0]    wait_cnt;

  logic             dec_ok;
  logic [4:0]       dec_op;
  logic [WIDTH-1:0] dec_a, dec_b;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       shamt;
  logic             is_jal;
  logic [WIDTH-1:0] imm_i, imm_u, imm_j, shamt_ext;

  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign funct7    = instr_q[31:25];
  assign shamt     = instr_q[24:20];
  assign is_jal    = (opcode == OPC_JAL);
  assign imm_i     = {{(WIDTH-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_u     = {{(WIDTH-20){1'b0}}, instr_q[31:12]};
  // JAL offset in halfwords (imm[20:1]); the ALU applies the <<1 and adds pc.
  assign imm_j     = {{(WIDTH-20){instr_q[31]}}, instr_q[31], instr_q[19:12],
                      instr_q[20], instr_q[30:21]};
  assign shamt_ext = {{(WIDTH-5){1'b0}}, shamt};

  assign rs1_addr = instr_q[19:15];
  assign rs2_addr = instr_q[24:20];

  // Decode of the latched instruction. The ALU only implements shift-by-one,
  // so immediate shifts with any other amount are rejected.
  always_comb begin
    dec_ok = 1'b0;
    dec_op = 5'b00000;
    dec_a  = rs1_data;
    dec_b  = rs2_data;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin dec_ok = 1'b1; dec_op = 5'b00001; end
            3'b111:  begin dec_ok = 1'b1; dec_op = 5'b01010; end
            3'b110:  begin dec_ok = 1'b1; dec_op = 5'b01100; end
            3'b100:  begin dec_ok = 1'b1; dec_op = 5'b01101; end
            default: dec_ok = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_ok = 1'b1;
          dec_op = 5'b00011;
        end
      end
      OPC_OPIMM: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: begin dec_ok = 1'b1; dec_op = 5'b00001; end
          3'b111: begin dec_ok = 1'b1; dec_op = 5'b01010; end
          3'b110: begin dec_ok = 1'b1; dec_op = 5'b01100; end
          3'b100: begin dec_ok = 1'b1; dec_op = 5'b01101; end
          3'b001: begin
            dec_b = shamt_ext;
            if (funct7 == 7'b0000000 && shamt == 5'd1) begin
              dec_ok = 1'b1;
              dec_op = 5'b01110;
            end
          end
          3'b101: begin
            dec_b = shamt_ext;
            if (shamt == 5'd1 && funct7 == 7'b0000000) begin
              dec_ok = 1'b1;
              dec_op = 5'b01111;
            end else if (shamt == 5'd1 && funct7 == 7'b0100000) begin
              dec_ok = 1'b1;
              dec_op = 5'b10000;
            end
          end
          default: dec_ok = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_ok = 1'b1;
        dec_op = 5'b10010;
        dec_a  = imm_u;
        dec_b  = '0;
      end
      OPC_AUIPC: begin
        dec_ok = 1'b1;
        dec_op = 5'b10011;
        dec_a  = pc_q;
        dec_b  = imm_u;
      end
      OPC_JAL: begin
        dec_ok = 1'b1;
        dec_op = 5'b10100;
        dec_a  = pc_q;
        dec_b  = imm_j;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state and strobes. alu_valid is only looked at in WAIT, and it takes
  // priority over the timeout on the final allowed cycle.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    rd_we       = 1'b0;
    jump_valid  = 1'b0;
    illegal     = 1'b0;
    timeout_err = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (dec_ok) begin
          state_next = S_ISSUE;
        end else begin
          illegal    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        alu_en     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (alu_valid) begin
          state_next = S_WB;
        end else if (wait_cnt == TMO) begin
          timeout_err = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_WB: begin
        rd_we      = (rd_addr != 5'd0);
        jump_valid = is_jal;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers. wait_cnt holds the number of the current WAIT cycle
  // (1 on the first), so the timeout fires on the TIMEOUT-th cycle in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= '0;
      pc_q        <= '0;
      wait_cnt    <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rd_addr     <= '0;
      rd_wdata    <= '0;
      jump_target <= '0;
    end else begin
      if (state == S_IDLE && instr_valid) begin
        instr_q <= instr;
        pc_q    <= pc;
      end
      if (state == S_DECODE && dec_ok) begin
        alu_op <= dec_op;
        alu_a  <= dec_a;
        alu_b  <= dec_b;
      end
      if (state == S_ISSUE)     wait_cnt <= CW'(1);
      else if (state == S_WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (state == S_WAIT && alu_valid) begin
        rd_addr <= instr_q[11:7];
        if (is_jal) begin
          rd_wdata    <= pc_q + WIDTH'(4);
          jump_target <= alu_result;
        end else begin
          rd_wdata <= alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl: models the regfile and the ALU
// responder, and predicts every observable from the instruction class that
// was generated.
module tb_alu_issue_ctrl;

  localparam int TMO = 8;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic        clk, rst;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        alu_en, alu_valid;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        illegal, timeout_err;

  logic [31:0] regs [32];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  int checks = 0;
  int errors = 0;

  // observations of one transaction (cycle numbers relative to accept = 0)
  int          ob_en_cyc, ob_en_cnt, ob_we_cyc, ob_we_cnt, ob_jv_cnt;
  int          ob_ill_cyc, ob_ill_cnt, ob_to_cyc, ob_ready_cyc;
  logic [4:0]  ob_op, ob_rd;
  logic [31:0] ob_a, ob_b, ob_wdata, ob_jt;

  // reference expectations
  logic        e_legal, e_bchk, e_jal;
  logic [4:0]  e_op, e_rd;
  logic [31:0] e_a, e_b;

  alu_issue_ctrl #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_valid(alu_valid), .alu_result(alu_result),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .illegal(illegal), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Present one instruction, act as the ALU answering lat cycles after
  // alu_en (lat=0: never) with value res, and record what happened.
  task automatic drive_op(input logic [31:0] ins, input logic [31:0] p,
                          input int lat, input logic [31:0] res);
    ob_en_cyc = -1; ob_en_cnt = 0; ob_we_cyc = -1; ob_we_cnt = 0; ob_jv_cnt = 0;
    ob_ill_cyc = -1; ob_ill_cnt = 0; ob_to_cyc = -1; ob_ready_cyc = -1;
    ob_op = 'x; ob_rd = 'x; ob_a = 'x; ob_b = 'x; ob_wdata = 'x; ob_jt = 'x;
    @(negedge clk);
    instr_valid = 1'b1; instr = ins; pc = p;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_before_accept got %b exp 1", instr_ready);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      alu_valid  = (ob_en_cyc > 0 && lat > 0 && k == ob_en_cyc + lat);
      alu_result = alu_valid ? res : $urandom;
      #1;
      if (alu_en) begin
        if (ob_en_cnt == 0) begin
          ob_en_cyc = k; ob_op = alu_op; ob_a = alu_a; ob_b = alu_b;
        end
        ob_en_cnt++;
      end
      if (rd_we) begin
        ob_we_cnt++; ob_we_cyc = k; ob_rd = rd_addr; ob_wdata = rd_wdata;
      end
      if (jump_valid) begin ob_jv_cnt++; ob_jt = jump_target; end
      if (illegal) begin ob_ill_cnt++; ob_ill_cyc = k; end
      if (timeout_err) ob_to_cyc = k;
      if (instr_ready) begin ob_ready_cyc = k; break; end
    end
    alu_valid = 1'b0;
  endtask

  // Build an instruction of a given class with random fields and set the
  // expected decode. Classes 0-14 are supported, 15-26 are not.
  task automatic gen_instr(input int kind, input logic [31:0] p, output logic [31:0] ins);
    logic [4:0]  rd, r1, r2, sh;
    logic [11:0] i12;
    logic [19:0] i20;
    logic [6:0]  f7;
    logic [2:0]  f3;
    int t;
    rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
    i12 = 12'($urandom); i20 = 20'($urandom);
    sh = 5'($urandom_range(0, 30));
    if (sh >= 5'd1) sh = sh + 5'd1;
    f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    t = $urandom_range(0, 3);
    f3 = (t == 0) ? 3'b001 : (t == 1) ? 3'b010 : (t == 2) ? 3'b011 : 3'b101;
    e_legal = 1'b1; e_bchk = 1'b1; e_jal = 1'b0; e_rd = rd;
    e_a = regs[r1]; e_b = regs[r2]; e_op = 5'b00000;
    case (kind)
      0:  begin ins = {7'h00, r2, r1, 3'b000, rd, OP_R}; e_op = 5'b00001; end
      1:  begin ins = {7'h20, r2, r1, 3'b000, rd, OP_R}; e_op = 5'b00011; end
      2:  begin ins = {7'h00, r2, r1, 3'b111, rd, OP_R}; e_op = 5'b01010; end
      3:  begin ins = {7'h00, r2, r1, 3'b110, rd, OP_R}; e_op = 5'b01100; end
      4:  begin ins = {7'h00, r2, r1, 3'b100, rd, OP_R}; e_op = 5'b01101; end
      5:  begin ins = {i12, r1, 3'b000, rd, OP_I}; e_op = 5'b00001; e_b = {{20{i12[11]}}, i12}; end
      6:  begin ins = {i12, r1, 3'b111, rd, OP_I}; e_op = 5'b01010; e_b = {{20{i12[11]}}, i12}; end
      7:  begin ins = {i12, r1, 3'b110, rd, OP_I}; e_op = 5'b01100; e_b = {{20{i12[11]}}, i12}; end
      8:  begin ins = {i12, r1, 3'b100, rd, OP_I}; e_op = 5'b01101; e_b = {{20{i12[11]}}, i12}; end
      9:  begin ins = {7'h00, 5'd1, r1, 3'b001, rd, OP_I}; e_op = 5'b01110; e_bchk = 1'b0; end
      10: begin ins = {7'h00, 5'd1, r1, 3'b101, rd, OP_I}; e_op = 5'b01111; e_bchk = 1'b0; end
      11: begin ins = {7'h20, 5'd1, r1, 3'b101, rd, OP_I}; e_op = 5'b10000; e_bchk = 1'b0; end
      12: begin ins = {i20, rd, OP_LUI}; e_op = 5'b10010; e_a = {12'h000, i20}; e_bchk = 1'b0; end
      13: begin ins = {i20, rd, OP_AUI}; e_op = 5'b10011; e_a = p; e_b = {12'h000, i20}; end
      14: begin
        ins = {i20[19], i20[9:0], i20[10], i20[18:11], rd, OP_JAL};
        e_op = 5'b10100; e_a = p; e_b = {{12{i20[19]}}, i20}; e_jal = 1'b1;
      end
      15: ins = {7'h00, sh, r1, 3'b001, rd, OP_I};
      16: ins = {f7, sh, r1, 3'b101, rd, OP_I};
      17: ins = {7'h00, r2, r1, f3, rd, OP_R};
      18: ins = {i12, r1, (t[0] ? 3'b010 : 3'b011), rd, OP_I};
      19: ins = {i12, r1, 3'b000, rd, 7'b1100111};
      20: ins = {i12, r1, 3'b010, rd, 7'b0000011};
      21: ins = {i12[11:5], r2, r1, 3'b010, i12[4:0], 7'b0100011};
      22: ins = {i12[11:5], r2, r1, 3'b000, i12[4:0], 7'b1100011};
      23: ins = {i12, r1, 3'b000, rd, 7'b0001111};
      24: ins = {i12, r1, 3'b000, rd, 7'b1110011};
      25: ins = {i12, r1, 3'b000, rd, 7'b1111111};
      default: ins = {7'h01, r2, r1, 3'b000, rd, OP_R};
    endcase
    if (kind >= 15) e_legal = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; alu_valid = 1'b0; alu_result = '0;
    instr = '0; pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({alu_en, rd_we, jump_valid, illegal, timeout_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes got %b exp 00000",
               {alu_en, rd_we, jump_valid, illegal, timeout_err});
    end
    checks++;
    if ({alu_op, alu_a, alu_b, rd_addr, rd_wdata, jump_target} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs got op=%0h a=%0h b=%0h rd=%0h wd=%0h jt=%0h exp all 0",
               alu_op, alu_a, alu_b, rd_addr, rd_wdata, jump_target);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b exp 1", instr_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    regs[1] = 32'h10;
    drive_op({12'hFFF, 5'd1, 3'b000, 5'd5, OP_I}, 32'h40, 1, 32'hF);
    checks++;
    if (ob_en_cyc !== 2 || ob_en_cnt !== 1) begin
      errors++; $display("[TB] FAIL addi_issue got cyc=%0d cnt=%0d exp 2/1", ob_en_cyc, ob_en_cnt);
    end
    checks++;
    if (ob_op !== 5'b00001 || ob_a !== 32'h10 || ob_b !== 32'hFFFF_FFFF) begin
      errors++; $display("[TB] FAIL addi_operands got op=%0h a=%0h b=%0h exp 1/10/ffffffff", ob_op, ob_a, ob_b);
    end
    checks++;
    if (ob_we_cyc !== 4 || ob_we_cnt !== 1 || ob_rd !== 5'd5 || ob_wdata !== 32'hF) begin
      errors++; $display("[TB] FAIL addi_wb got cyc=%0d cnt=%0d rd=%0d wd=%0h exp 4/1/5/f",
                         ob_we_cyc, ob_we_cnt, ob_rd, ob_wdata);
    end
    checks++;
    if (ob_ready_cyc !== 5) begin
      errors++; $display("[TB] FAIL addi_ready got %0d exp 5", ob_ready_cyc);
    end
  endtask

  task automatic test_add_x0();
    drive_op({7'h00, 5'd2, 5'd1, 3'b000, 5'd0, OP_R}, 32'h44, 1, 32'h1234);
    checks++;
    if (ob_en_cnt !== 1 || ob_we_cnt !== 0) begin
      errors++; $display("[TB] FAIL add_x0 got en_cnt=%0d we_cnt=%0d exp 1/0", ob_en_cnt, ob_we_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    ins[0] = {7'h00, 5'd2, 5'd3, 3'b001, 5'd3, OP_I};
    ins[1] = {12'h000, 5'd2, 3'b010, 5'd1, 7'b0000011};
    for (int i = 0; i < 2; i++) begin
      drive_op(ins[i], 32'h80, 1, 32'h5);
      checks++;
      if (ob_ill_cyc !== 1 || ob_ill_cnt !== 1 || ob_en_cnt !== 0 || ob_we_cnt !== 0 || ob_ready_cyc !== 2) begin
        errors++; $display("[TB] FAIL illegal_%0d got ill=%0d/%0d en=%0d we=%0d rdy=%0d exp 1/1/0/0/2",
                           i, ob_ill_cyc, ob_ill_cnt, ob_en_cnt, ob_we_cnt, ob_ready_cyc);
      end
    end
  endtask

  task automatic test_jal();
    drive_op({1'b0, 10'd4, 1'b0, 8'd0, 5'd1, OP_JAL}, 32'h100, 1, 32'h108);
    checks++;
    if (ob_op !== 5'b10100 || ob_a !== 32'h100 || ob_b !== 32'h4) begin
      errors++; $display("[TB] FAIL jal_operands got op=%0h a=%0h b=%0h exp 14/100/4", ob_op, ob_a, ob_b);
    end
    checks++;
    if (ob_jv_cnt !== 1 || ob_jt !== 32'h108 || ob_wdata !== 32'h104 || ob_we_cyc !== 4) begin
      errors++; $display("[TB] FAIL jal_wb got jv=%0d jt=%0h wd=%0h cyc=%0d exp 1/108/104/4",
                         ob_jv_cnt, ob_jt, ob_wdata, ob_we_cyc);
    end
    drive_op({1'b0, 10'd2, 1'b0, 8'd0, 5'd0, OP_JAL}, 32'h200, 2, 32'h204);
    checks++;
    if (ob_jv_cnt !== 1 || ob_jt !== 32'h204 || ob_we_cnt !== 0) begin
      errors++; $display("[TB] FAIL jal_x0 got jv=%0d jt=%0h we=%0d exp 1/204/0", ob_jv_cnt, ob_jt, ob_we_cnt);
    end
    drive_op({1'b0, 10'd2, 1'b0, 8'd0, 5'd2, OP_JAL}, 32'hFFFF_FFFC, 1, 32'h0000_0000);
    checks++;
    if (ob_wdata !== 32'h0 || ob_we_cnt !== 1) begin
      errors++; $display("[TB] FAIL jal_pc_wrap got wd=%0h we=%0d exp 0/1", ob_wdata, ob_we_cnt);
    end
  endtask

  task automatic test_timeout();
    drive_op({12'h001, 5'd1, 3'b000, 5'd5, OP_I}, 32'h300, 0, 32'h0);
    checks++;
    if (ob_to_cyc !== 2 + TMO || ob_we_cnt !== 0 || ob_ready_cyc !== 3 + TMO) begin
      errors++; $display("[TB] FAIL timeout got to=%0d we=%0d rdy=%0d exp %0d/0/%0d",
                         ob_to_cyc, ob_we_cnt, ob_ready_cyc, 2 + TMO, 3 + TMO);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      alu_valid = (i == 0); alu_result = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (rd_we !== 1'b0 || alu_en !== 1'b0 || instr_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL late_valid_%0d got we=%b en=%b rdy=%b exp 0/0/1", i, rd_we, alu_en, instr_ready);
      end
    end
    alu_valid = 1'b0;
    drive_op({12'h002, 5'd1, 3'b000, 5'd6, OP_I}, 32'h304, TMO, 32'hCAFE);
    checks++;
    if (ob_to_cyc !== -1 || ob_we_cyc !== 3 + TMO || ob_wdata !== 32'hCAFE || ob_ready_cyc !== 4 + TMO) begin
      errors++; $display("[TB] FAIL valid_wins got to=%0d we=%0d wd=%0h rdy=%0d exp -1/%0d/cafe/%0d",
                         ob_to_cyc, ob_we_cyc, ob_wdata, ob_ready_cyc, 3 + TMO, 4 + TMO);
    end
  endtask

  task automatic test_reset_in_wait();
    int we_seen = 0;
    regs[1] = 32'h77;
    @(negedge clk);
    instr_valid = 1'b1; instr = {12'hFFF, 5'd1, 3'b000, 5'd5, OP_I}; pc = 32'h400;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({alu_en, rd_we, jump_valid, illegal, timeout_err} !== 5'b0 ||
        {alu_op, alu_a, alu_b, rd_addr, rd_wdata, jump_target, rs1_addr} !== '0 || instr_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_wait got op=%0h a=%0h b=%0h rs1=%0d rdy=%b exp all 0, rdy 1",
                         alu_op, alu_a, alu_b, rs1_addr, instr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_valid = 1'b1; alu_result = 32'h99;
      #1;
      if (rd_we) we_seen++;
    end
    alu_valid = 1'b0;
    checks++;
    if (we_seen !== 0) begin
      errors++; $display("[TB] FAIL reset_no_wb got %0d writes exp 0", we_seen);
    end
  endtask

  task automatic test_back_to_back();
    int en_cnt = 0, we_cnt = 0, busy_rdy = 0, last_en = -10;
    int en_c [2];
    int we_c [2];
    logic [31:0] en_a [2];
    logic [4:0]  en_o [2];
    logic [4:0]  we_r [2];
    regs[1] = 32'h1111_0001; regs[2] = 32'h2222_0002; regs[3] = 32'h3333_0003;
    @(negedge clk);
    instr_valid = 1'b1; instr = {7'h00, 5'd2, 5'd1, 3'b000, 5'd6, OP_R}; pc = 32'h500;
    @(posedge clk);
    #1 instr = {12'h0F0, 5'd3, 3'b100, 5'd7, OP_I}; pc = 32'h504;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      alu_valid = (k == last_en + 1);
      alu_result = 32'hA000_0000 + 32'(k);
      if (k == 6) instr_valid = 1'b0;
      #1;
      if (alu_en) begin
        if (en_cnt < 2) begin en_c[en_cnt] = k; en_a[en_cnt] = alu_a; en_o[en_cnt] = alu_op; end
        en_cnt++; last_en = k;
      end
      if (rd_we) begin
        if (we_cnt < 2) begin we_c[we_cnt] = k; we_r[we_cnt] = rd_addr; end
        we_cnt++;
      end
      if (instr_ready && k <= 4) busy_rdy++;
    end
    alu_valid = 1'b0;
    checks++;
    if (en_cnt !== 2 || busy_rdy !== 0) begin
      errors++; $display("[TB] FAIL b2b_count got en=%0d busy_ready=%0d exp 2/0", en_cnt, busy_rdy);
    end else begin
      checks++;
      if (en_c[0] !== 2 || en_c[1] !== 7 || en_a[0] !== regs[1] || en_a[1] !== regs[3] || en_o[1] !== 5'b01101) begin
        errors++; $display("[TB] FAIL b2b_issue got cyc=%0d/%0d a=%0h/%0h op1=%0h exp 2/7 %0h/%0h d",
                           en_c[0], en_c[1], en_a[0], en_a[1], en_o[1], regs[1], regs[3]);
      end
    end
    checks++;
    if (we_cnt !== 2 || we_c[0] !== 4 || we_c[1] !== 9 || we_r[0] !== 5'd6 || we_r[1] !== 5'd7) begin
      errors++; $display("[TB] FAIL b2b_wb got cnt=%0d exp 2 writes at 4/9 to x6/x7", we_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, p, res;
    int kind, lat, ok;
    for (int n = 0; n < 150; n++) begin
      for (int j = 0; j < 3; j++) regs[$urandom_range(1, 31)] = $urandom;
      kind = $urandom_range(0, 26);
      lat  = $urandom_range(0, TMO + 1);
      p    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      res  = $urandom;
      gen_instr(kind, p, ins);
      drive_op(ins, p, lat, res);
      ok = (lat >= 1 && lat <= TMO) ? 1 : 0;
      if (!e_legal) begin
        checks++;
        if (ob_ill_cyc !== 1 || ob_ill_cnt !== 1 || ob_en_cnt !== 0 || ob_we_cnt !== 0 || ob_ready_cyc !== 2) begin
          errors++; $display("[TB] FAIL rnd_illegal k=%0d ins=%h got ill=%0d en=%0d we=%0d rdy=%0d exp 1/0/0/2",
                             kind, ins, ob_ill_cyc, ob_en_cnt, ob_we_cnt, ob_ready_cyc);
        end
      end else begin
        checks++;
        if (ob_ill_cnt !== 0 || ob_en_cyc !== 2 || ob_en_cnt !== 1) begin
          errors++; $display("[TB] FAIL rnd_issue k=%0d ins=%h got ill=%0d en=%0d/%0d exp 0 2/1",
                             kind, ins, ob_ill_cnt, ob_en_cyc, ob_en_cnt);
        end
        checks++;
        if (ob_op !== e_op || ob_a !== e_a || (e_bchk && ob_b !== e_b)) begin
          errors++; $display("[TB] FAIL rnd_decode k=%0d ins=%h got op=%0h a=%0h b=%0h exp op=%0h a=%0h b=%0h",
                             kind, ins, ob_op, ob_a, ob_b, e_op, e_a, e_b);
        end
        if (ok == 1) begin
          checks++;
          if (ob_to_cyc !== -1 || ob_we_cnt !== ((e_rd != 5'd0) ? 1 : 0) || ob_jv_cnt !== (e_jal ? 1 : 0) ||
              ob_ready_cyc !== lat + 4) begin
            errors++; $display("[TB] FAIL rnd_done k=%0d lat=%0d got to=%0d we=%0d jv=%0d rdy=%0d", kind, lat,
                               ob_to_cyc, ob_we_cnt, ob_jv_cnt, ob_ready_cyc);
          end
          if (e_rd != 5'd0) begin
            checks++;
            if (ob_we_cyc !== lat + 3 || ob_rd !== e_rd || ob_wdata !== (e_jal ? p + 32'd4 : res)) begin
              errors++; $display("[TB] FAIL rnd_wb k=%0d got cyc=%0d rd=%0d wd=%0h exp %0d/%0d/%0h", kind,
                                 ob_we_cyc, ob_rd, ob_wdata, lat + 3, e_rd, e_jal ? p + 32'd4 : res);
            end
          end
          if (e_jal) begin
            checks++;
            if (ob_jt !== res) begin
              errors++; $display("[TB] FAIL rnd_jump got %0h exp %0h", ob_jt, res);
            end
          end
        end else begin
          checks++;
          if (ob_to_cyc !== 2 + TMO || ob_we_cnt !== 0 || ob_jv_cnt !== 0 || ob_ready_cyc !== 3 + TMO) begin
            errors++; $display("[TB] FAIL rnd_timeout k=%0d lat=%0d got to=%0d we=%0d jv=%0d rdy=%0d", kind, lat,
                               ob_to_cyc, ob_we_cnt, ob_jv_cnt, ob_ready_cyc);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
    test_reset();
    test_addi();
    test_add_x0();
    test_illegal();
    test_jal();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
